vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 25 ++
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the pixel generators.
// The master side produces the scan; the slave side consumes it.
interface vga_timing_gen_if #(
  parameter int FRAME_W = 8
);
  logic               pclk_en;
  logic [9:0]         h_cnt;
  logic [9:0]         v_cnt;
  logic               hsync;
  logic               vsync;
  logic               valid;
  logic               line_tick;
  logic               frame_tick;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    output pclk_en, h_cnt, v_cnt, hsync, vsync, valid,
           line_tick, frame_tick, frame_cnt
  );

  modport slave (
    input pclk_en, h_cnt, v_cnt, hsync, vsync, valid,
          line_tick, frame_tick, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster scan generator: pixel-tick divider, h/v counters, sync and
// active-video decodes delayed to match the pixel pipeline, plus line/frame ticks.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIPE_DLY  = 2,
  parameter int FRAME_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int STAGES  = (PIPE_DLY == 0) ? 1 : PIPE_DLY;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]   div;
  logic               pclk_en;
  logic [9:0]         h_cnt;
  logic [9:0]         v_cnt;
  logic               line_tick;
  logic               frame_tick;
  logic [FRAME_W-1:0] frame_cnt;
  logic               h_last;
  logic               v_last;
  logic               hs_raw;
  logic               vs_raw;
  logic               vd_raw;
  logic [STAGES-1:0]  hs_pipe;
  logic [STAGES-1:0]  vs_pipe;
  logic [STAGES-1:0]  vd_pipe;

  // pclk_en is registered, so it rises the clk after div reaches its last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      pclk_en <= 1'b0;
    end else begin
      pclk_en <= (div == DIV_LAST);
      if (div == DIV_LAST)
        div <= '0;
      else
        div <= div + DIV_W'(1);
    end
  end

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      line_tick  <= pclk_en && h_last;
      frame_tick <= pclk_en && h_last && v_last;
      if (pclk_en) begin
        if (h_last) begin
          h_cnt <= '0;
          if (v_last) begin
            v_cnt     <= '0;
            frame_cnt <= frame_cnt + FRAME_W'(1);
          end else begin
            v_cnt <= v_cnt + 10'd1;
          end
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign hs_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign vd_raw = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  // With no pipeline delay requested, the single stage just registers the
  // raw decode every clk instead of waiting for a pixel tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      vd_pipe <= '0;
    end else if ((PIPE_DLY == 0) || pclk_en) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        vd_pipe[i] <= vd_pipe[i-1];
      end
      hs_pipe[0] <= hs_raw;
      vs_pipe[0] <= vs_raw;
      vd_pipe[0] <= vd_raw;
    end
  end

  assign vga.pclk_en    = pclk_en;
  assign vga.h_cnt      = h_cnt;
  assign vga.v_cnt      = v_cnt;
  assign vga.hsync      = hs_pipe[STAGES-1];
  assign vga.vsync      = vs_pipe[STAGES-1];
  assign vga.valid      = vd_pipe[STAGES-1];
  assign vga.line_tick  = line_tick;
  assign vga.frame_tick = frame_tick;
  assign vga.frame_cnt  = frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (16x8 pixel frame, 4 clks per
// pixel) so several whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int D   = 4;
  localparam int HV  = 8;
  localparam int HF  = 2;
  localparam int HS  = 3;
  localparam int HB  = 3;
  localparam int VV  = 4;
  localparam int VF  = 1;
  localparam int VS  = 2;
  localparam int VB  = 1;
  localparam int PD  = 2;
  localparam int FW  = 2;
  localparam int HT  = HV + HF + HS + HB;
  localparam int VT  = VV + VF + VS + VB;
  localparam int FT  = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   t   = 0;
  int   checks = 0;
  int   passes = 0;

  vga_timing_gen_if #(.FRAME_W(FW)) vga ();

  vga_timing_gen #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIPE_DLY(PD), .FRAME_W(FW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vga)
  );

  always #5 clk = ~clk;

  // Clks elapsed since the last clk that saw reset.
  always @(posedge clk) begin
    if (rst) t <= 0;
    else     t <= t + 1;
  end

  typedef struct {
    int   t;
    logic pe;
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic vd;
    logic lt;
    logic ft;
    int   fc;
  } vec_t;

  function automatic logic [27:0] pack(logic pe, int h, int v, logic hs, logic vs,
                                       logic vd, logic lt, logic ft, int fc);
    return {pe, 10'(h), 10'(v), hs, vs, vd, lt, ft, 2'(fc)};
  endfunction

  function automatic logic [27:0] actual();
    return {vga.pclk_en, vga.h_cnt, vga.v_cnt, vga.hsync, vga.vsync, vga.valid,
            vga.line_tick, vga.frame_tick, vga.frame_cnt};
  endfunction

  // Reference: everything follows from the number of pixel ticks completed.
  function automatic logic [27:0] model(int tt);
    int p, pp, q, qh, qv;
    logic pe, lt, ft, hs, vs, vd;
    if (tt == 0) return pack(0, 0, 0, 1, 1, 0, 0, 0, 0);
    pe = (tt % D) == 0;
    p  = (tt - 1) / D;
    pp = (tt >= 2) ? (tt - 2) / D : 0;
    lt = (p != pp) && (p % HT == 0);
    ft = lt && (p % FT == 0);
    if (p >= PD) begin
      q  = p - PD;
      qh = q % HT;
      qv = (q / HT) % VT;
      hs = !(qh >= HV + HF && qh < HV + HF + HS);
      vs = !(qv >= VV + VF && qv < VV + VF + VS);
      vd = (qh < HV) && (qv < VV);
    end else begin
      hs = 1'b1;
      vs = 1'b1;
      vd = 1'b0;
    end
    return pack(pe, p % HT, (p / HT) % VT, hs, vs, vd, lt, ft, (p / FT) % (1 << FW));
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
  endtask

  task automatic apply_stimulus(input int target);
    int budget;
    budget = 5000;
    while (t < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (t != target) check_output("advance", t, target);
  endtask

  task automatic wait_frame_tick(output int lo_h, output int lo_v, output int hi_vd,
                                 output int n_lt);
    int budget;
    lo_h = 0; lo_v = 0; hi_vd = 0; n_lt = 0;
    budget = FT * D + 50;
    do begin
      @(negedge clk);
      budget--;
      if (vga.pclk_en && !vga.hsync) lo_h++;
      if (vga.pclk_en && !vga.vsync) lo_v++;
      if (vga.pclk_en && vga.valid) hi_vd++;
      if (vga.line_tick) n_lt++;
    end while (!vga.frame_tick && budget > 0);
    if (budget == 0) check_output("frame_tick_timeout", 0, 1);
  endtask

  vec_t tbl[14];
  int lo_h, lo_v, hi_vd, n_lt;

  initial begin
    tbl[0]  = '{t:0,   pe:0, h:0,  v:0, hs:1, vs:1, vd:0, lt:0, ft:0, fc:0};
    tbl[1]  = '{t:3,   pe:0, h:0,  v:0, hs:1, vs:1, vd:0, lt:0, ft:0, fc:0};
    tbl[2]  = '{t:4,   pe:1, h:0,  v:0, hs:1, vs:1, vd:0, lt:0, ft:0, fc:0};
    tbl[3]  = '{t:5,   pe:0, h:1,  v:0, hs:1, vs:1, vd:0, lt:0, ft:0, fc:0};
    tbl[4]  = '{t:9,   pe:0, h:2,  v:0, hs:1, vs:1, vd:1, lt:0, ft:0, fc:0};
    tbl[5]  = '{t:48,  pe:1, h:11, v:0, hs:1, vs:1, vd:0, lt:0, ft:0, fc:0};
    tbl[6]  = '{t:49,  pe:0, h:12, v:0, hs:0, vs:1, vd:0, lt:0, ft:0, fc:0};
    tbl[7]  = '{t:61,  pe:0, h:15, v:0, hs:1, vs:1, vd:0, lt:0, ft:0, fc:0};
    tbl[8]  = '{t:65,  pe:0, h:0,  v:1, hs:1, vs:1, vd:0, lt:1, ft:0, fc:0};
    tbl[9]  = '{t:66,  pe:0, h:0,  v:1, hs:1, vs:1, vd:0, lt:0, ft:0, fc:0};
    tbl[10] = '{t:329, pe:0, h:2,  v:5, hs:1, vs:0, vd:0, lt:0, ft:0, fc:0};
    tbl[11] = '{t:385, pe:0, h:0,  v:6, hs:1, vs:0, vd:0, lt:1, ft:0, fc:0};
    tbl[12] = '{t:513, pe:0, h:0,  v:0, hs:1, vs:1, vd:0, lt:1, ft:1, fc:1};
    tbl[13] = '{t:514, pe:0, h:0,  v:0, hs:1, vs:1, vd:0, lt:0, ft:0, fc:1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(tbl[i].t);
      check_output($sformatf("vec%0d", i), actual(),
                   pack(tbl[i].pe, tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs,
                        tbl[i].vd, tbl[i].lt, tbl[i].ft, tbl[i].fc));
    end

    // One full frame: pulse widths counted in pixel ticks, then frame_cnt wrap.
    wait_frame_tick(lo_h, lo_v, hi_vd, n_lt);
    check_output("hsync_low_ticks", lo_h, VT * HS);
    check_output("vsync_low_ticks", lo_v, VS * HT);
    check_output("valid_ticks", hi_vd, VV * HV);
    check_output("line_ticks", n_lt, VT);
    check_output("frame_cnt_2", vga.frame_cnt, 2);
    check_output("frame_and_line", {vga.frame_tick, vga.line_tick}, 2'b11);
    wait_frame_tick(lo_h, lo_v, hi_vd, n_lt);
    check_output("frame_cnt_3", vga.frame_cnt, 3);
    wait_frame_tick(lo_h, lo_v, hi_vd, n_lt);
    check_output("frame_cnt_wrap", vga.frame_cnt, 0);
    check_output("counters_home", {vga.h_cnt, vga.v_cnt}, 20'd0);

    // Reset in the middle of an hsync pulse, then replay the power-up timing.
    apply_stimulus(t + ((13 + HT - ((t - 1) / D) % HT) % HT) * D);
    check_output("pre_reset_state", {vga.h_cnt, vga.hsync}, {10'd13, 1'b0});
    check_output("pre_reset_model", actual(), model(t));
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_reset", actual(), pack(0, 0, 0, 1, 1, 0, 0, 0, 0));
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(tbl[i].t);
      check_output($sformatf("restart%0d", i), actual(),
                   pack(tbl[i].pe, tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs,
                        tbl[i].vd, tbl[i].lt, tbl[i].ft, tbl[i].fc));
    end

    // Random run lengths and reset bursts against the reference model.
    for (int it = 0; it < 10; it++) begin
      int len;
      len = $urandom_range(50, 600);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        check_output("rand_run", actual(), model(t));
      end
      rst = 1'b1;
      len = $urandom_range(1, 3);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        check_output("rand_rst", actual(), model(t));
      end
      rst = 1'b0;
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
